// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver (5-9 data bits, parity, 1/2 stop, break) with receive FIFO.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority decisions at every sample point.
module uart_rx_param #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_perr,
    output logic                          rx_ferr,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          overrun,
    output logic                          break_det,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT) + 1;
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int IW           = $clog2(DATA_BITS);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] H_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_t;

    state_t               state;
    logic                 rx_m, rs, bv;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic                 sidx;
    logic [DATA_BITS-1:0] data;
    logic                 par, ferr_r, ferr_n, perr_n, brk, sample;
    logic                 push_req, push_perr, push_ferr;
    logic [DATA_BITS-1:0] push_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rs   <= 1'b1;
        end else begin
            rx_m <= rx;
            rs   <= rx_m;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Window is the current rs plus the two previous samples.
    logic [1:0] hist;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist <= 2'b11;
        else        hist <= {hist[0], rs};
    end
    assign bv = (hist[1] & hist[0]) | (hist[1] & rs) | (hist[0] & rs);
`else
    assign bv = rs;
`endif

    assign sample = cnt == C_LAST;
    assign ferr_n = ferr_r | ~bv;
    assign perr_n = (PARITY != 0) && ((^data ^ par) != (PARITY == 2));
    assign brk    = ferr_n & ~|data & ~par;
    assign busy   = state != S_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            sidx      <= 1'b0;
            data      <= '0;
            par       <= 1'b0;
            ferr_r    <= 1'b0;
            push_req  <= 1'b0;
            push_data <= '0;
            push_perr <= 1'b0;
            push_ferr <= 1'b0;
            break_det <= 1'b0;
        end else begin
            push_req  <= 1'b0;
            break_det <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt    <= '0;
                    idx    <= '0;
                    sidx   <= 1'b0;
                    par    <= 1'b0;
                    ferr_r <= 1'b0;
                    if (!rs) state <= S_START;
                end
                S_START:
                    if (cnt == H_LAST) begin
                        cnt   <= '0;
                        state <= bv ? S_IDLE : S_DATA;
                    end else cnt <= cnt + 1'b1;
                S_DATA:
                    if (sample) begin
                        cnt       <= '0;
                        data[idx] <= bv;
                        idx       <= idx + 1'b1;
                        if (idx == IW'(DATA_BITS - 1)) begin
                            idx   <= '0;
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end
                    end else cnt <= cnt + 1'b1;
                S_PARITY:
                    if (sample) begin
                        cnt   <= '0;
                        par   <= bv;
                        state <= S_STOP;
                    end else cnt <= cnt + 1'b1;
                S_STOP:
                    if (sample) begin
                        cnt    <= '0;
                        ferr_r <= ferr_n;
                        if (sidx == 1'(STOP_BITS - 1)) begin
                            sidx <= 1'b0;
                            if (brk) begin
                                break_det <= 1'b1;
                                state     <= S_WAIT_HIGH;
                            end else begin
                                push_req  <= 1'b1;
                                push_data <= data;
                                push_perr <= perr_n;
                                push_ferr <= ferr_n;
                                state     <= ferr_n ? S_WAIT_HIGH : S_IDLE;
                            end
                        end else sidx <= 1'b1;
                    end else cnt <= cnt + 1'b1;
                S_WAIT_HIGH:
                    if (rs) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [DATA_BITS+1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wp, rp;
    logic                 full, pop, wr;

    assign full     = fifo_count == (AW+1)'(FIFO_DEPTH);
    assign rx_valid = fifo_count != '0;
    assign pop      = rx_valid & rx_ready;
    assign wr       = push_req & (~full | pop);
    assign {rx_data, rx_perr, rx_ferr} = mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp         <= '0;
            rp         <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            overrun <= push_req & full & ~pop;
            if (wr) begin
                mem[wp] <= {push_data, push_perr, push_ferr};
                wp      <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            fifo_count <= fifo_count + (AW+1)'(wr) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed checks of uart_rx_param across three configurations.
module tb_uart_rx_param;
    localparam int C0 = 868, H0 = 434, C = 16, H = 8;

    logic clk = 0, rst_n = 0, line = 1;
    int   sel = 0, tests = 0, fails = 0, cyc = 0, stop_start = 0;
    logic rx0, rx1, rx2;
    logic rx_ready0 = 0, rx_ready1 = 0, rx_ready2 = 0;

    logic [7:0] rx_data0; logic rx_perr0, rx_ferr0, rx_valid0, overrun0, break_det0, busy0; logic [2:0] fifo_count0;
    logic [6:0] rx_data1; logic rx_perr1, rx_ferr1, rx_valid1, overrun1, break_det1, busy1; logic [2:0] fifo_count1;
    logic [7:0] rx_data2; logic rx_perr2, rx_ferr2, rx_valid2, overrun2, break_det2, busy2; logic [2:0] fifo_count2;

    assign rx0 = (sel == 0) ? line : 1'b1;
    assign rx1 = (sel == 1) ? line : 1'b1;
    assign rx2 = (sel == 2) ? line : 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param d0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .rx_data(rx_data0), .rx_perr(rx_perr0), .rx_ferr(rx_ferr0),
        .rx_valid(rx_valid0), .rx_ready(rx_ready0), .overrun(overrun0), .break_det(break_det0),
        .busy(busy0), .fifo_count(fifo_count0));

    uart_rx_param #(.CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(1)) d1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .rx_data(rx_data1), .rx_perr(rx_perr1), .rx_ferr(rx_ferr1),
        .rx_valid(rx_valid1), .rx_ready(rx_ready1), .overrun(overrun1), .break_det(break_det1),
        .busy(busy1), .fifo_count(fifo_count1));

    uart_rx_param #(.CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .STOP_BITS(2)) d2 (
        .clk(clk), .rst_n(rst_n), .rx(rx2), .rx_data(rx_data2), .rx_perr(rx_perr2), .rx_ferr(rx_ferr2),
        .rx_valid(rx_valid2), .rx_ready(rx_ready2), .overrun(overrun2), .break_det(break_det2),
        .busy(busy2), .fifo_count(fifo_count2));

    // Frame bits LSB first; par < 0 means no parity bit; line keeps the last bit on return.
    task automatic send(input int nd, input logic [8:0] d, input int par, input int ns, input logic [1:0] sv, input int c);
        logic [12:0] b;
        int n;
        b = '0;
        for (int i = 0; i < nd; i++) b[1+i] = d[i];
        n = 1 + nd;
        if (par >= 0) begin b[n] = par[0]; n++; end
        for (int i = 0; i < ns; i++) begin b[n] = sv[i]; n++; end
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            if (i == n - ns) stop_start = cyc;
            line = b[i];
            repeat (c) @(posedge clk);
            #1;
        end
    endtask

    task automatic pop(input int w);
        @(posedge clk); #1;
        if (w == 1) rx_ready1 = 1; else rx_ready2 = 1;
        @(posedge clk); #1;
        rx_ready1 = 0;
        rx_ready2 = 0;
    endtask

    task automatic test_reset;
        @(negedge clk); @(negedge clk);
        tests++;
        if ({rx_data0, rx_perr0, rx_ferr0, rx_valid0, overrun0, break_det0, busy0, fifo_count0} !== 16'h0) begin
            fails++;
            $display("FAIL reset_d0 got %h exp 0000", {rx_data0, rx_perr0, rx_ferr0, rx_valid0, overrun0, break_det0, busy0, fifo_count0});
        end
        tests++;
        if ({rx_valid2, busy2, fifo_count2, break_det2, overrun2} !== 7'h0) begin
            fails++;
            $display("FAIL reset_d2 got %b exp 0000000", {rx_valid2, busy2, fifo_count2, break_det2, overrun2});
        end
        @(posedge clk); #1 rst_n = 1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_8n1;
        logic [7:0] got [2];
        logic [1:0] ef [2];
        logic [7:0] exp8 [2];
        int lat [2];
        int np;
        exp8[0] = 8'hA5; exp8[1] = 8'h3C;
        np = 0;
        sel = 0;
        rx_ready0 = 1;
        fork
            begin
                send(8, 9'h0A5, -1, 1, 2'b01, C0);
                send(8, 9'h03C, -1, 1, 2'b01, C0);
            end
            for (int k = 0; k < 22000 && np < 2; k++) begin
                @(negedge clk);
                if (rx_valid0) begin
                    got[np] = rx_data0; ef[np] = {rx_perr0, rx_ferr0}; lat[np] = cyc - stop_start; np++;
                end
            end
        join
        rx_ready0 = 0;
        tests++;
        if (np !== 2) begin fails++; $display("FAIL 8n1_pops got %0d exp 2", np); end
        for (int i = 0; i < 2; i++) begin
            tests++;
            if ({got[i], ef[i]} !== {exp8[i], 2'b00}) begin
                fails++;
                $display("FAIL 8n1_frame%0d got %h/%b exp %h/00", i, got[i], ef[i], exp8[i]);
            end
            tests++;
            if (lat[i] > H0 + 4) begin
                fails++;
                $display("FAIL 8n1_latency%0d got %0d exp <= %0d", i, lat[i], H0 + 4);
            end
        end
    endtask

    task automatic test_parity;
        sel = 1;
        send(7, 9'h055, 0, 1, 2'b01, C);
        send(7, 9'h055, 1, 1, 2'b01, C);
        repeat (4) @(negedge clk);
        tests++;
        if (fifo_count1 !== 3'd2) begin fails++; $display("FAIL par_count got %0d exp 2", fifo_count1); end
        tests++;
        if ({rx_data1, rx_perr1, rx_ferr1} !== {7'h55, 1'b0, 1'b0}) begin
            fails++; $display("FAIL par_good got %h/%b%b exp 55/00", rx_data1, rx_perr1, rx_ferr1);
        end
        pop(1);
        @(negedge clk);
        tests++;
        if ({rx_data1, rx_perr1, rx_ferr1} !== {7'h55, 1'b1, 1'b0}) begin
            fails++; $display("FAIL par_bad got %h/%b%b exp 55/10", rx_data1, rx_perr1, rx_ferr1);
        end
        pop(1);
    endtask

    task automatic test_stop2;
        sel = 2;
        send(8, 9'h081, -1, 2, 2'b01, C);
        repeat (3 * C) @(negedge clk);
        tests++;
        if ({busy2, fifo_count2} !== {1'b1, 3'd1}) begin
            fails++; $display("FAIL stop2_wait got busy=%b count=%0d exp busy=1 count=1", busy2, fifo_count2);
        end
        tests++;
        if ({rx_data2, rx_perr2, rx_ferr2} !== {8'h81, 1'b0, 1'b1}) begin
            fails++; $display("FAIL stop2_ferr got %h/%b%b exp 81/01", rx_data2, rx_perr2, rx_ferr2);
        end
        @(posedge clk); #1 line = 1;
        repeat (8) @(negedge clk);
        tests++;
        if (busy2 !== 1'b0) begin fails++; $display("FAIL stop2_release got busy=%b exp 0", busy2); end
        send(8, 9'h042, -1, 2, 2'b11, C);
        repeat (4) @(negedge clk);
        pop(2);
        @(negedge clk);
        tests++;
        if ({fifo_count2, rx_data2, rx_perr2, rx_ferr2} !== {3'd1, 8'h42, 1'b0, 1'b0}) begin
            fails++; $display("FAIL stop2_next got cnt=%0d %h/%b%b exp cnt=1 42/00", fifo_count2, rx_data2, rx_perr2, rx_ferr2);
        end
        pop(2);
    endtask

    task automatic test_break;
        int bc, idle_cnt, ovc;
        bc = 0; idle_cnt = 0; ovc = 0;
        sel = 2;
        @(posedge clk); #1 line = 0;
        for (int k = 0; k < 2 * 12 * C; k++) begin
            @(negedge clk);
            bc = bc + break_det2;
            ovc = ovc + overrun2;
            if (k >= 4 && !busy2) idle_cnt++;
        end
        tests++;
        if (bc !== 1) begin fails++; $display("FAIL break_pulse got %0d exp 1", bc); end
        tests++;
        if ({idle_cnt, ovc} !== {32'd0, 32'd0}) begin
            fails++; $display("FAIL break_busy got idle_cycles=%0d overruns=%0d exp 0/0", idle_cnt, ovc);
        end
        tests++;
        if (fifo_count2 !== 3'd0) begin fails++; $display("FAIL break_nopush got %0d exp 0", fifo_count2); end
        @(posedge clk); #1 line = 1;
        repeat (8) @(negedge clk);
        tests++;
        if (busy2 !== 1'b0) begin fails++; $display("FAIL break_release got busy=%b exp 0", busy2); end
    endtask

    task automatic test_overrun;
        int oc;
        oc = 0;
        sel = 2;
        fork
            for (int i = 1; i <= 5; i++) send(8, 9'(i), -1, 2, 2'b11, C);
            for (int k = 0; k < 5 * 12 * C + 40; k++) begin
                @(negedge clk);
                oc = oc + overrun2;
            end
        join
        tests++;
        if ({fifo_count2, oc} !== {3'd4, 32'd1}) begin
            fails++; $display("FAIL ovr_state got count=%0d pulses=%0d exp 4/1", fifo_count2, oc);
        end
        for (int i = 1; i <= 4; i++) begin
            tests++;
            if ({rx_valid2, rx_data2} !== {1'b1, 8'(i)}) begin
                fails++; $display("FAIL ovr_drain%0d got v=%b %h exp v=1 %h", i, rx_valid2, rx_data2, 8'(i));
            end
            pop(2);
            @(negedge clk);
        end
        tests++;
        if ({rx_valid2, fifo_count2} !== 4'b0) begin
            fails++; $display("FAIL ovr_empty got v=%b count=%0d exp 0/0", rx_valid2, fifo_count2);
        end
    endtask

    task automatic test_glitch;
        logic [7:0] exp_d;
`ifdef UART_RX_MAJORITY_EN
        exp_d = 8'h00;
`else
        exp_d = 8'h08;
`endif
        sel = 2;
        fork
            send(8, 9'h000, -1, 2, 2'b11, C);
            begin
                @(posedge clk); #1;
                repeat (4 * C + H) @(posedge clk);
                #2 line = 1;
                @(posedge clk);
                #2 line = 0;
            end
        join
        repeat (4) @(negedge clk);
        tests++;
        if ({fifo_count2, rx_data2, rx_perr2, rx_ferr2} !== {3'd1, exp_d, 1'b0, 1'b0}) begin
            fails++; $display("FAIL glitch got cnt=%0d %h/%b%b exp cnt=1 %h/00", fifo_count2, rx_data2, rx_perr2, rx_ferr2, exp_d);
        end
        pop(2);
    endtask

    task automatic test_reset_mid;
        sel = 2;
        send(8, 9'h011, -1, 2, 2'b11, C);
        @(posedge clk); #1 line = 0;
        repeat (3 * C) @(posedge clk);
        #3;
        rst_n = 0;
        line = 1;
        #1;
        tests++;
        if ({busy2, rx_valid2, fifo_count2, rx_data2} !== 13'h0) begin
            fails++; $display("FAIL rstmid_clear got busy=%b v=%b cnt=%0d d=%h exp all 0", busy2, rx_valid2, fifo_count2, rx_data2);
        end
        @(posedge clk); #1 rst_n = 1;
        repeat (5 * C) @(negedge clk);
        tests++;
        if ({busy2, fifo_count2} !== 4'b0) begin
            fails++; $display("FAIL rstmid_idle got busy=%b cnt=%0d exp 0/0", busy2, fifo_count2);
        end
        send(8, 9'h05A, -1, 2, 2'b11, C);
        repeat (4) @(negedge clk);
        tests++;
        if ({fifo_count2, rx_data2, rx_perr2, rx_ferr2} !== {3'd1, 8'h5A, 1'b0, 1'b0}) begin
            fails++; $display("FAIL rstmid_next got cnt=%0d %h/%b%b exp cnt=1 5a/00", fifo_count2, rx_data2, rx_perr2, rx_ferr2);
        end
    endtask

    initial begin
        test_reset;
        test_8n1;
        test_parity;
        test_stop2;
        test_break;
        test_overrun;
        test_glitch;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
